// File: rtl/board_io_pkg.sv
// board_io_pkg: register map, display control bit positions and hex-to-segment decode
package board_io_pkg;
   localparam logic [3:0] ADDR_SW        = 4'h0;
   localparam logic [3:0] ADDR_BTN       = 4'h1;
   localparam logic [3:0] ADDR_BTN_EVT   = 4'h2;
   localparam logic [3:0] ADDR_LED       = 4'h3;
   localparam logic [3:0] ADDR_SSD_VALUE = 4'h4;
   localparam logic [3:0] ADDR_SSD_CTRL  = 4'h5;
   localparam logic [3:0] ADDR_IRQ_MASK  = 4'h6;
   localparam int CTRL_DP_LSB = 8;
   localparam int CTRL_BLANK  = 16;
   function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
      case (v)
         4'h0: return 7'h40;
         4'h1: return 7'h79;
         4'h2: return 7'h24;
         4'h3: return 7'h30;
         4'h4: return 7'h19;
         4'h5: return 7'h12;
         4'h6: return 7'h02;
         4'h7: return 7'h78;
         4'h8: return 7'h00;
         4'h9: return 7'h10;
         4'hA: return 7'h08;
         4'hB: return 7'h03;
         4'hC: return 7'h46;
         4'hD: return 7'h21;
         4'hE: return 7'h06;
         default: return 7'h0E;
      endcase
   endfunction
endpackage

// File: rtl/io_debounce.sv
// io_debounce: synchronises one raw pin and only follows it after it has been stable long enough
module io_debounce
   import board_io_pkg::*;
#(
   parameter int CYCLES = 250000
) (
   input  logic clk,
   input  logic reset,
   input  logic din_i,
   output logic level_o,
   output logic rise_o
);
   localparam int CW = CYCLES > 1 ? $clog2(CYCLES) : 1;
   logic          s1_q, s2_q, level_q, level_d, flip;
   logic [CW-1:0] cnt_q, cnt_d;
   // count cycles of disagreement between the synced pin and the level; flip at terminal count
   always_comb begin
      flip    = (s2_q != level_q) && (cnt_q == CW'(CYCLES - 1));
      cnt_d   = (s2_q == level_q || flip) ? '0 : cnt_q + CW'(1);
      level_d = flip ? ~level_q : level_q;
   end
   // two-flop synchroniser, counter and debounced level
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         s1_q    <= din_i;
         s2_q    <= s1_q;
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end
   assign level_o = level_q;
   assign rise_o  = flip & ~level_q;
endmodule

// File: rtl/board_io_hub.sv
// board_io_hub: register-mapped switches, debounced buttons with sticky events/IRQ, LEDs and 7-seg scan
module board_io_hub
   import board_io_pkg::*;
#(
   parameter int NUM_BTNS        = 5,
   parameter int NUM_SW          = 16,
   parameter int NUM_LEDS        = 16,
   parameter int NUM_DIGITS      = 8,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int SCAN_DIV        = 100000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_BTNS-1:0]   btn_in,
   input  logic [NUM_SW-1:0]     sw_in,
   input  logic [3:0]            bus_addr,
   input  logic                  bus_wr,
   input  logic                  bus_rd,
   input  logic [31:0]           bus_wdata,
   output logic [31:0]           bus_rdata,
   output logic                  bus_rvalid,
   output logic                  irq,
   output logic [NUM_LEDS-1:0]   leds,
   output logic [NUM_DIGITS-1:0] an,
   output logic [6:0]            seg,
   output logic                  dp
);
   localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
   localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   localparam int VW = 4 * NUM_DIGITS;
   logic [NUM_SW-1:0]     sw_s1_q, sw_q;
   logic [NUM_BTNS-1:0]   btn_lvl, btn_rise, evt_q, evt_d, mask_q;
   logic [NUM_LEDS-1:0]   led_q;
   logic [VW-1:0]         val_q;
   logic [NUM_DIGITS-1:0] en_q, dpm_q, an_q, an_d;
   logic                  blank_q, wr_evt, digit_on, scan_tc;
   logic [PW-1:0]         pre_q, pre_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [31:0]           rd_word, rdata_q;
   logic                  rvalid_q, dp_q, dp_d;
   logic [6:0]            seg_q, seg_d;

   for (genvar i = 0; i < NUM_BTNS; i++) begin : g_db
      io_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk     (clk),
         .reset   (reset),
         .din_i   (btn_in[i]),
         .level_o (btn_lvl[i]),
         .rise_o  (btn_rise[i])
      );
   end

   // read mux, events (a new press beats a same-cycle clear) and the display scan next state
   always_comb begin
      case (bus_addr)
         ADDR_SW:        rd_word = 32'(sw_q);
         ADDR_BTN:       rd_word = 32'(btn_lvl);
         ADDR_BTN_EVT:   rd_word = 32'(evt_q);
         ADDR_LED:       rd_word = 32'(led_q);
         ADDR_SSD_VALUE: rd_word = 32'(val_q);
         ADDR_SSD_CTRL:  rd_word = {15'd0, blank_q, 8'(dpm_q), 8'(en_q)};
         ADDR_IRQ_MASK:  rd_word = 32'(mask_q);
         default:        rd_word = 32'd0;
      endcase
      wr_evt   = bus_wr && bus_addr == ADDR_BTN_EVT;
      evt_d    = (evt_q & ~(wr_evt ? bus_wdata[NUM_BTNS-1:0] : '0)) | btn_rise;
      scan_tc  = pre_q == PW'(SCAN_DIV - 1);
      pre_d    = scan_tc ? '0 : pre_q + PW'(1);
      idx_d    = !scan_tc ? idx_q : (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
      digit_on = en_q[idx_q] & ~blank_q;
      an_d     = digit_on ? ~(NUM_DIGITS'(1) << idx_q) : '1;
      seg_d    = digit_on ? hex_to_seg(val_q[idx_q*4 +: 4]) : 7'h7F;
      dp_d     = digit_on ? ~dpm_q[idx_q] : 1'b1;
   end

   // switch synchroniser and the writable register file
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sw_s1_q <= '0;
         sw_q    <= '0;
         evt_q   <= '0;
         led_q   <= '0;
         val_q   <= '0;
         en_q    <= '0;
         dpm_q   <= '0;
         blank_q <= 1'b0;
         mask_q  <= '0;
      end else begin
         sw_s1_q <= sw_in;
         sw_q    <= sw_s1_q;
         evt_q   <= evt_d;
         if (bus_wr && bus_addr == ADDR_LED) led_q <= bus_wdata[NUM_LEDS-1:0];
         if (bus_wr && bus_addr == ADDR_SSD_VALUE) val_q <= bus_wdata[VW-1:0];
         if (bus_wr && bus_addr == ADDR_SSD_CTRL) begin
            en_q    <= bus_wdata[NUM_DIGITS-1:0];
            dpm_q   <= bus_wdata[CTRL_DP_LSB +: NUM_DIGITS];
            blank_q <= bus_wdata[CTRL_BLANK];
         end
         if (bus_wr && bus_addr == ADDR_IRQ_MASK) mask_q <= bus_wdata[NUM_BTNS-1:0];
      end
   end

   // one-cycle read response; data holds until the next read
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rvalid_q <= bus_rd;
         if (bus_rd) rdata_q <= rd_word;
      end
   end

   // scan prescaler, digit index and registered display outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_q <= '0;
         idx_q <= '0;
         an_q  <= '1;
         seg_q <= 7'h7F;
         dp_q  <= 1'b1;
      end else begin
         pre_q <= pre_d;
         idx_q <= idx_d;
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
      end
   end

   assign bus_rdata  = rdata_q;
   assign bus_rvalid = rvalid_q;
   assign irq        = |(evt_q & mask_q);
   assign leds       = led_q;
   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
endmodule

// File: tb/tb_board_io_hub.sv
// tb_board_io_hub: directed checks of registers, debounce, events/IRQ and display scan
module tb_board_io_hub;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [4:0]  btn_in = '0;
   logic [15:0] sw_in = '0;
   logic [3:0]  bus_addr = '0;
   logic        bus_wr = 1'b0;
   logic        bus_rd = 1'b0;
   logic [31:0] bus_wdata = '0;
   logic [31:0] bus_rdata;
   logic        bus_rvalid, irq, dp;
   logic [15:0] leds;
   logic [3:0]  an;
   logic [6:0]  seg;
   int total = 0, passed = 0, failed = 0;
   logic [3:0] an_a [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
   logic [6:0] seg_a [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
   logic [3:0] an_b [4] = '{4'hE, 4'hF, 4'hB, 4'hF};
   logic [6:0] seg_b [4] = '{7'h19, 7'h7F, 7'h24, 7'h7F};
   logic       dp_b [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

   board_io_hub #(
      .NUM_BTNS(5), .NUM_SW(16), .NUM_LEDS(16), .NUM_DIGITS(4),
      .DEBOUNCE_CYCLES(4), .SCAN_DIV(2)
   ) dut (
      .clk(clk), .reset(reset), .btn_in(btn_in), .sw_in(sw_in),
      .bus_addr(bus_addr), .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid), .irq(irq),
      .leds(leds), .an(an), .seg(seg), .dp(dp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      bus_addr = a;
      bus_wdata = d;
      bus_wr = 1'b1;
      @(negedge clk);
      bus_wr = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
      @(negedge clk);
      bus_addr = a;
      bus_rd = 1'b1;
      @(negedge clk);
      bus_rd = 1'b0;
      chk({tag, "_rvalid"}, 32'(bus_rvalid), 32'd1);
      chk(tag, bus_rdata, exp);
      @(negedge clk);
      chk({tag, "_rvalid_end"}, 32'(bus_rvalid), 32'd0);
      chk({tag, "_hold"}, bus_rdata, exp);
   endtask

   task automatic align_digit0();
      int n = 0;
      logic [3:0] prev = an;
      logic found = 1'b0;
      while (!found && n < 20) begin
         @(negedge clk);
         n++;
         found = (an == 4'hE) && (prev != 4'hE);
         prev = an;
      end
      chk("align_digit0", 32'(found), 32'd1);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      wr(4'h3, 32'hFFFF);
      wr(4'h5, 32'h0000000F);
      repeat (5) @(negedge clk);
      chk("led_drive", 32'(leds), 32'hFFFF);
      rd_chk("led_read", 4'h3, 32'hFFFF);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("rst_leds", 32'(leds), 32'h0);
      chk("rst_an", 32'(an), 32'hF);
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_dp", 32'(dp), 32'h1);
      chk("rst_rdata", bus_rdata, 32'h0);
      chk("rst_rvalid", 32'(bus_rvalid), 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      @(posedge clk);
      #1 chk("rst_an_edge", 32'(an), 32'hF);
      @(negedge clk);
      reset = 1'b0;
      for (int a = 0; a < 7; a++) rd_chk("reg_after_rst", 4'(a), 32'h0);

      @(negedge clk);
      btn_in = 5'b00001;
      repeat (2) @(negedge clk);
      btn_in = 5'b0;
      repeat (10) @(negedge clk);
      rd_chk("btn_glitch", 4'h1, 32'h0);
      rd_chk("evt_glitch", 4'h2, 32'h0);
      @(negedge clk);
      btn_in = 5'b00001;
      repeat (10) @(negedge clk);
      rd_chk("btn_press", 4'h1, 32'h1);
      rd_chk("evt_press", 4'h2, 32'h1);
      btn_in = 5'b0;
      repeat (8) @(negedge clk);
      rd_chk("btn_release", 4'h1, 32'h0);
      rd_chk("evt_sticky", 4'h2, 32'h1);
      chk("irq_unmasked_off", 32'(irq), 32'h0);
      wr(4'h6, 32'h1);
      chk("irq_on", 32'(irq), 32'h1);
      wr(4'h2, 32'h1);
      chk("irq_cleared", 32'(irq), 32'h0);
      rd_chk("evt_w1c", 4'h2, 32'h0);
      @(negedge clk);
      btn_in = 5'b00001;
      repeat (8) @(negedge clk);
      chk("irq_press", 32'(irq), 32'h1);
      btn_in = 5'b0;
      repeat (8) @(negedge clk);
      wr(4'h2, 32'h1);
      chk("irq_cleared2", 32'(irq), 32'h0);
      @(negedge clk);
      btn_in = 5'b00001;
      repeat (5) @(negedge clk);
      bus_addr = 4'h2;
      bus_wdata = 32'h1;
      bus_wr = 1'b1;
      @(negedge clk);
      bus_wr = 1'b0;
      rd_chk("evt_set_wins", 4'h2, 32'h1);
      chk("irq_set_wins", 32'(irq), 32'h1);
      btn_in = 5'b0;

      @(negedge clk);
      bus_addr = 4'h3;
      bus_wdata = 32'h1234;
      bus_wr = 1'b1;
      bus_rd = 1'b1;
      @(negedge clk);
      bus_wr = 1'b0;
      bus_rd = 1'b0;
      chk("rdwr_old_value", bus_rdata, 32'h0);
      chk("rdwr_leds", 32'(leds), 32'h1234);
      rd_chk("led_new", 4'h3, 32'h1234);

      wr(4'h4, 32'h1234);
      wr(4'h5, 32'h0000000F);
      align_digit0();
      for (int k = 0; k < 8; k++) begin
         if (k > 0) @(negedge clk);
         chk("scan_an", 32'(an), 32'(an_a[k/2]));
         chk("scan_seg", 32'(seg), 32'(seg_a[k/2]));
         chk("scan_dp", 32'(dp), 32'h1);
      end
      wr(4'h5, 32'h0001000F);
      repeat (2) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("blank_an", 32'(an), 32'hF);
         chk("blank_seg", 32'(seg), 32'h7F);
         chk("blank_dp", 32'(dp), 32'h1);
      end
      wr(4'h5, 32'h00000105);
      align_digit0();
      for (int k = 0; k < 8; k++) begin
         if (k > 0) @(negedge clk);
         chk("mask_an", 32'(an), 32'(an_b[k/2]));
         chk("mask_seg", 32'(seg), 32'(seg_b[k/2]));
         chk("mask_dp", 32'(dp), 32'(dp_b[k/2]));
      end
      rd_chk("ctrl_read", 4'h5, 32'h00000105);
      wr(4'h6, 32'hFFFFFFFF);
      rd_chk("mask_width", 4'h6, 32'h1F);

      sw_in = 16'hA5A5;
      repeat (3) @(negedge clk);
      rd_chk("sw_read", 4'h0, 32'hA5A5);
      wr(4'hF, 32'hDEADBEEF);
      rd_chk("unmapped", 4'hF, 32'h0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
